// File: rtl/list_builder.sv
// rtl/list_builder.sv - writes a valid/ready value stream into node RAM as a singly linked list
module list_builder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] node_count,
    output logic [DATA_W-1:0] exp_sum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WR_VAL,
        S_WR_NEXT,
        S_DONE
    } state_t;

    // Base address of the last node slot that still fits in the RAM.
    localparam logic [ADDR_W-1:0] P_MAX = {{(ADDR_W-1){1'b1}}, 1'b0};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   p_q, p_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic                last_q, last_d;
    logic                full_q, full_d;
    logic                ovf_q, ovf_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]   sum_q, sum_d;

    logic [ADDR_W-1:0]   p_plus2;
    logic                term;

    assign p_plus2 = p_q + ADDR_W'(2);
    assign term    = last_q | full_q;

    // Next-state logic: list walk LOAD -> WR_VAL -> WR_NEXT, one node per pass.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        val_d   = val_q;
        last_d  = last_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    p_d     = '0;
                    count_d = '0;
                    sum_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    val_d   = in_data;
                    last_d  = in_last;
                    full_d  = (p_q == P_MAX);
                    state_d = S_WR_VAL;
                end
            end
            S_WR_VAL: begin
                count_d = (count_q == '1) ? count_q : count_q + ADDR_W'(1);
                sum_d   = sum_q + val_q;
                state_d = S_WR_NEXT;
            end
            S_WR_NEXT: begin
                if (term) begin
                    // Only a cut at capacity counts as overflow; a last value in the final slot is a clean end.
                    ovf_d   = full_q & ~last_q;
                    state_d = S_DONE;
                end else begin
                    p_d     = p_plus2;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset that aborts any list in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            val_q   <= '0;
            last_q  <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            val_q   <= val_d;
            last_q  <= last_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            sum_q   <= sum_d;
        end
    end

    // Output decode purely from registered state; the RAM bus is zero whenever no write is issued.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_WR_VAL: begin
                mem_we    = 1'b1;
                mem_addr  = p_q + ADDR_W'(1);
                mem_wdata = val_q;
            end
            S_WR_NEXT: begin
                mem_we    = 1'b1;
                mem_addr  = p_q;
                mem_wdata = term ? '0 : DATA_W'(p_plus2);
            end
            default: ;
        endcase
    end

    assign in_ready   = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD) || (state_q == S_WR_VAL) || (state_q == S_WR_NEXT);
    assign done       = (state_q == S_DONE);
    assign overflow   = ovf_q;
    assign node_count = count_q;
    assign exp_sum    = sum_q;

endmodule

// File: tb/tb_list_builder.sv
// tb/tb_list_builder.sv - randomized scoreboard bench for list_builder
module tb_list_builder;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int CAP    = 1 << (ADDR_W - 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W-1:0] node_count;
    logic [DATA_W-1:0] exp_sum;

    list_builder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .overflow(overflow),
        .node_count(node_count), .exp_sum(exp_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] vq[$];
    bit          lq[$];
    logic [DATA_W-1:0] ram[0:(1<<ADDR_W)-1];

    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;

    int          m_i;
    logic [31:0] m_sum;
    bit          m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every RAM write is popped against the scoreboard; idle cycles must show a quiet bus.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we === 1'b1) begin
                ram[mem_addr] <= mem_wdata;
                if (wq.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write", mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(e.a));
                    chk("wr_data", 64'(mem_wdata), 64'(e.d));
                end
            end else begin
                chk("idle_bus", {29'd0, mem_addr, mem_wdata}, 64'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy_we_busy_done_ovf"}, {in_ready, mem_we, busy, done, overflow}, 0);
        chk({tag, "_addr_wdata"}, {29'd0, mem_addr, mem_wdata}, 0);
        chk({tag, "_count_sum"}, {29'd0, node_count, exp_sum}, 0);
    endtask

    task automatic start_list();
        m_i = 0;
        m_sum = '0;
        m_ovf = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_ready", 64'(in_ready), 1);
        chk("start_done_ovf", {done, overflow}, 0);
        chk("start_count_sum", {29'd0, node_count, exp_sum}, 0);
    endtask

    // Offers one value; on handshake the two expected writes go to the scoreboard.
    task automatic send(input logic [31:0] v, input bit last, input bit poke_start, output bit term);
        bit hs = 1'b0;
        in_data  = v;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (in_ready === 1'b1) begin
                hs = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!hs) begin
            checks++;
            $display("FAIL handshake_timeout: got no in_ready expected in_ready within 50 cycles");
            in_valid = 1'b0;
            term = 1'b1;
            return;
        end
        term  = last || (m_i == CAP - 1);
        m_ovf = term && !last;
        wq.push_back('{a: ADDR_W'(2 * m_i + 1), d: v});
        wq.push_back('{a: ADDR_W'(2 * m_i), d: term ? 32'd0 : 32'(2 * m_i + 2)});
        m_sum = m_sum + v;
        m_i++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
        @(negedge clk);
        chk("wrval_in_ready", 64'(in_ready), 0);
        if (poke_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_count", 64'(node_count), 64'(m_i));
        chk("mid_sum", 64'(exp_sum), 64'(m_sum));
        @(negedge clk);
        chk("h3_in_ready", 64'(in_ready), 64'(!term));
        chk("h3_done", 64'(done), 64'(term));
    endtask

    task automatic run_list(input bit gaps);
        bit term = 1'b0;
        int p;
        logic [31:0] s;
        start_list();
        for (int i = 0; i < vq.size(); i++) begin
            send(vq[i], lq[i], i == 1, term);
            if (term) break;
            if (gaps) repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        chk("end_done", 64'(done), 1);
        chk("end_overflow", 64'(overflow), 64'(m_ovf));
        chk("end_count", 64'(node_count), 64'(m_i));
        chk("end_sum", 64'(exp_sum), 64'(m_sum));
        chk("end_queue_empty", 64'(wq.size()), 0);
        p = 0;
        s = '0;
        for (int k = 0; k < CAP; k++) begin
            s = s + ram[p + 1];
            if (ram[p] == 0) break;
            p = int'(ram[p][ADDR_W-1:0]);
        end
        chk("loopback_sum", 64'(s), 64'(m_sum));
        in_valid = 1'b1;
        in_data  = $urandom;
        repeat (5) begin
            @(negedge clk);
            chk("after_done_in_ready", 64'(in_ready), 0);
        end
        in_valid = 1'b0;
    endtask

    initial begin
        bit term;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");
        mon_en = 1'b1;

        vq = '{32'd5, 32'd7, 32'd9};                 lq = '{0, 0, 1};       run_list(0);
        vq = '{32'h2A};                              lq = '{1};             run_list(0);
        vq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6}; lq = '{0, 0, 0, 0, 0, 0}; run_list(0);
        vq = '{32'hFFFF_FFFF, 32'd2};                lq = '{0, 1};          run_list(1);
        vq = '{32'd10, 32'd20, 32'd30, 32'd40};      lq = '{0, 0, 0, 1};    run_list(1);

        // Abort in the middle of the second node: value written, pointer write must never appear.
        start_list();
        send(32'hAAAA_0001, 1'b0, 1'b0, term);
        in_data  = 32'hBBBB_0002;
        in_last  = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && in_ready !== 1'b1; k++) @(negedge clk);
        wq.push_back('{a: ADDR_W'(3), d: 32'hBBBB_0002});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_queue_empty", 64'(wq.size()), 0);
        vq = '{32'h55};                              lq = '{1};             run_list(0);

        for (int t = 0; t < 20; t++) begin
            int n;
            vq.delete();
            lq.delete();
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(CAP + 1, CAP + 2);
                for (int i = 0; i < n; i++) begin vq.push_back($urandom); lq.push_back(1'b0); end
            end else begin
                n = $urandom_range(1, CAP);
                for (int i = 0; i < n; i++) begin vq.push_back($urandom); lq.push_back(i == n - 1); end
            end
            run_list(1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
